uart_line_writer: RTL and testbench
===================================

UART_LINE_WRITER -- requirements
Module: uart_line_writer

Interface
REQ-001 Parameter WIDTH, default 640: pixels per line.
REQ-002 Parameter HEIGHT, default 480: lines per frame.
REQ-003 Parameter BPP, default 4: bits per pixel; legal values 1, 2, 4, 8.
REQ-004 Parameters END_CODE 8'h55, ACK_CODE 8'hAA, NAK_CODE 8'hEE: line terminator, success answer and failure answer.
REQ-005 Parameter TIMEOUT_CYCLES, default 1_000_000: inter-byte timeout, used only under REQ-026.
REQ-006 Derived widths: AW = clog2(WIDTH*HEIGHT); NBYTES = WIDTH*BPP/8.
REQ-007 Port clk, input, 1: the single clock.
REQ-008 Port rst_n, input, 1: asynchronous active-low reset.
REQ-009 Port rx_data, input, 8: received UART byte.
REQ-010 Port rx_valid, input, 1: rx_data valid.
REQ-011 Port rx_ready, output, 1: block accepts a byte; transfer occurs on rx_valid && rx_ready.
REQ-012 Ports tx_data (output, 8), tx_valid (output, 1), tx_ready (input, 1): answer byte handshake.
REQ-013 Ports wr_en (output, 1), wr_addr (output, AW), wr_data (output, BPP): framebuffer write port.
REQ-014 Ports line_done, err_row, busy (outputs, 1 each): success pulse, out-of-range-row flag, not-idle indication.

Function
REQ-015 Frame format: ROW_HI byte, ROW_LO byte (16-bit row index), NBYTES payload bytes, one terminator byte.
REQ-016 States: ROW_HI, ROW_LO, PAYLOAD, UNPACK, TERM, ANSWER; reset state ROW_HI; busy = 1 in every state except ROW_HI.
REQ-017 rx_ready = 1 in ROW_HI, ROW_LO, PAYLOAD and TERM; rx_ready = 0 in UNPACK and ANSWER.
REQ-018 ROW_LO accept: latch row and go to PAYLOAD; if row >= HEIGHT, set err_row = 1 and suppress all writes for this frame.
REQ-019 PAYLOAD accept: latch the byte and go to UNPACK.
REQ-020 UNPACK issues 8/BPP consecutive single-cycle writes, starting the cycle after the byte is accepted; pixels are taken MSB-first (first pixel = byte[7:8-BPP]).
REQ-021 Write address = row*WIDTH + col. col starts at 0 per frame and increments per pixel. wr_addr is an AW-bit unsigned value; no wrap is possible for a legal row.
REQ-022 After the last pixel of a byte, return to PAYLOAD. After the last pixel of byte NBYTES, go to TERM.
REQ-023 TERM accept: go to ANSWER. tx_data = ACK_CODE if byte == END_CODE and err_row == 0; otherwise tx_data = NAK_CODE.
REQ-024 ANSWER: hold tx_valid = 1 and tx_data stable until tx_ready.
- On the handshake cycle: go to ROW_HI and clear err_row.
- If the answer is ACK, pulse line_done for exactly that one cycle.
- rx bytes presented while in ANSWER are not accepted.
REQ-025 Pixels written before a bad terminator remain written; no rollback.

Configuration
REQ-026 Macro ULW_TIMEOUT_EN selects inter-byte timeout behaviour.
- When defined: a counter runs in ROW_LO, PAYLOAD and TERM and clears on every accepted byte. On reaching TIMEOUT_CYCLES-1 it forces ANSWER with NAK_CODE, and the counter and col are cleared.
- When undefined: no counter exists and the block waits indefinitely.

Reset
REQ-027 While rst_n = 0, all of the following hold asynchronously:
- state = ROW_HI
- rx_ready = 1
- tx_valid = 0, tx_data = 0
- wr_en = 0, wr_addr = 0, wr_data = 0
- line_done = 0, err_row = 0, busy = 0
- col = 0, row = 0
REQ-028 Reset mid-frame or mid-answer discards the partial frame and any pending answer; no further writes occur.

Verification
REQ-029 Row 0x0001, 320 bytes of 0x12, terminator 0x55 -> writes addr 640=1, 641=2 … 1279=2; tx 0xAA; line_done pulses once.
REQ-030 Row 0x01E0 (480), 320 bytes, 0x55 -> wr_en never asserted; err_row = 1; tx 0xEE.
REQ-031 Row 0x01DF, 320 bytes, terminator 0x00 -> last write addr 307199; tx 0xEE; no line_done.
REQ-032 tx_ready held low for 10 cycles in ANSWER -> tx_valid and tx_data stable, rx_ready = 0, no bytes consumed.
REQ-033 With ULW_TIMEOUT_EN and TIMEOUT_CYCLES = 100, stop after 5 payload bytes -> tx 0xEE after 100 cycles, then the next frame is accepted normally. Without the macro, the block stays in PAYLOAD.

Source files
------------

// File: rtl/uart_line_writer.sv
// uart_line_writer: receives one framebuffer line over a byte stream and
// writes its pixels into a framebuffer port, then answers ACK or NAK.
//
// Frame: ROW_HI, ROW_LO, WIDTH*BPP/8 payload bytes, terminator byte.
// Each payload byte is unpacked MSB-first into 8/BPP single-cycle writes.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rx_data/valid/ready  inbound byte stream (transfer on valid && ready)
//   tx_data/valid/ready  answer byte (ACK_CODE or NAK_CODE)
//   wr_en/addr/data      framebuffer write port, addr = row*WIDTH + col
//   line_done            one-cycle pulse after an ACK answer is taken
//   err_row              row index of the current frame is out of range
//   busy                 block is inside a frame or answer
//
// Optional build macro ULW_TIMEOUT_EN: inter-byte timeout that aborts the
// frame with a NAK after TIMEOUT_CYCLES idle cycles. Undefined by default,
// in which case the block waits indefinitely for the next byte.
module uart_line_writer #(
  parameter int unsigned WIDTH          = 640,
  parameter int unsigned HEIGHT         = 480,
  parameter int unsigned BPP            = 4,
  parameter logic [7:0]  END_CODE       = 8'h55,
  parameter logic [7:0]  ACK_CODE       = 8'hAA,
  parameter logic [7:0]  NAK_CODE       = 8'hEE,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  localparam int unsigned AW            = $clog2(WIDTH * HEIGHT)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic           rx_ready,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           wr_en,
  output logic [AW-1:0]  wr_addr,
  output logic [BPP-1:0] wr_data,
  output logic           line_done,
  output logic           err_row,
  output logic           busy
);

  localparam int unsigned PPB = 8 / BPP;              // pixels per byte
  localparam int unsigned CW  = $clog2(WIDTH + 1);    // column counter
  localparam int unsigned PW  = $clog2(PPB + 1);      // pixel-in-byte counter

  // Elaboration-time parameter sanity checks
  if (!(BPP == 1 || BPP == 2 || BPP == 4 || BPP == 8)) begin : g_bpp_chk
    $error("uart_line_writer: BPP must be 1, 2, 4 or 8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_tmo_chk
    $error("uart_line_writer: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_ROW_HI,
    S_ROW_LO,
    S_PAYLOAD,
    S_UNPACK,
    S_TERM,
    S_ANSWER
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      row_hi_q, row_hi_d;
  logic [15:0]     row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [7:0]      sh_q, sh_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            rx_ready_q, rx_ready_d;
  logic            busy_q, busy_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [BPP-1:0]  wr_data_q, wr_data_d;
  logic            line_done_q, line_done_d;
  logic            accept;

`ifdef ULW_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0]   tmo_q, tmo_d;
`endif

  assign accept = rx_valid && rx_ready_q;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ROW_HI;
      row_hi_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      sh_q        <= '0;
      pix_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rx_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      line_done_q <= 1'b0;
`ifdef ULW_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_hi_q    <= row_hi_d;
      row_q       <= row_d;
      col_q       <= col_d;
      sh_q        <= sh_d;
      pix_q       <= pix_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      line_done_q <= line_done_d;
`ifdef ULW_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Next-state and next-output logic; outputs are registered from the
  // next state so they line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    row_hi_d    = row_hi_q;
    row_d       = row_q;
    col_d       = col_q;
    sh_d        = sh_q;
    pix_d       = pix_q;
    ack_d       = ack_q;
    err_d       = err_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    line_done_d = 1'b0;
`ifdef ULW_TIMEOUT_EN
    tmo_d       = '0;
`endif

    unique case (state_q)
      S_ROW_HI: begin
        if (accept) begin
          row_hi_d = rx_data;
          state_d  = S_ROW_LO;
        end
      end

      S_ROW_LO: begin
        if (accept) begin
          row_d   = {row_hi_q, rx_data};
          err_d   = 32'({row_hi_q, rx_data}) >= 32'(HEIGHT);
          col_d   = '0;
          state_d = S_PAYLOAD;
        end
      end

      // First pixel of the byte goes out straight from rx_data
      S_PAYLOAD: begin
        if (accept) begin
          wr_en_d   = !err_q;
          wr_data_d = rx_data[7 -: BPP];
          wr_addr_d = AW'(32'(row_q) * 32'(WIDTH) + 32'(col_q));
          sh_d      = rx_data << BPP;
          col_d     = col_q + CW'(1);
          pix_d     = PW'(1);
          state_d   = S_UNPACK;
        end
      end

      // Remaining pixels come from the shifted byte; once all are issued,
      // the column count tells whether the line payload is complete.
      S_UNPACK: begin
        if (pix_q == PW'(PPB)) begin
          state_d = (col_q == CW'(WIDTH)) ? S_TERM : S_PAYLOAD;
        end else begin
          wr_en_d   = !err_q;
          wr_data_d = sh_q[7 -: BPP];
          wr_addr_d = AW'(32'(row_q) * 32'(WIDTH) + 32'(col_q));
          sh_d      = sh_q << BPP;
          col_d     = col_q + CW'(1);
          pix_d     = pix_q + PW'(1);
        end
      end

      S_TERM: begin
        if (accept) begin
          ack_d      = (rx_data == END_CODE) && !err_q;
          tx_data_d  = ((rx_data == END_CODE) && !err_q) ? ACK_CODE : NAK_CODE;
          tx_valid_d = 1'b1;
          state_d    = S_ANSWER;
        end
      end

      S_ANSWER: begin
        if (tx_ready) begin
          tx_valid_d  = 1'b0;
          err_d       = 1'b0;
          col_d       = '0;
          line_done_d = ack_q;
          state_d     = S_ROW_HI;
        end
      end

      default: state_d = S_ROW_HI;
    endcase

`ifdef ULW_TIMEOUT_EN
    // Idle counter while waiting for a byte inside a frame; expiry aborts
    // the frame with a NAK.
    if (state_q == S_ROW_LO || state_q == S_PAYLOAD || state_q == S_TERM) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_d      = '0;
        col_d      = '0;
        ack_d      = 1'b0;
        tx_data_d  = NAK_CODE;
        tx_valid_d = 1'b1;
        state_d    = S_ANSWER;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
`endif

    rx_ready_d = (state_d == S_ROW_HI) || (state_d == S_ROW_LO) ||
                 (state_d == S_PAYLOAD) || (state_d == S_TERM);
    busy_d     = (state_d != S_ROW_HI);
  end

  assign rx_ready  = rx_ready_q;
  assign busy      = busy_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign line_done = line_done_q;
  assign err_row   = err_q;

endmodule

// File: tb/tb_uart_line_writer.sv
// Bench for uart_line_writer with default geometry (640x480, 4 bpp).
module tb_uart_line_writer;

  localparam int unsigned AW     = $clog2(640 * 480);
  localparam int unsigned NB     = 320;   // payload bytes per line

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          line_done;
  logic          err_row;
  logic          busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    data;
  } wr_t;

  typedef struct {
    logic [15:0] row;
    logic [7:0]  fill;
    bit          rnd;
    logic [7:0]  term;
    logic [7:0]  exp_tx;
    bit          exp_done;
    int          stall;
  } vec_t;

  wr_t        wq[$];
  int         done_cnt;
  logic [7:0] pl [NB];
  vec_t       vt [7];

  uart_line_writer #(.TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .line_done (line_done),
    .err_row   (err_row),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Write / pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) wq.push_back('{addr: wr_addr, data: wr_data});
      if (line_done) done_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until the block takes it
  task automatic send_byte(input logic [7:0] b);
    int  n = 0;
    logic acc = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    rx_valid = 1'b0;
    if (!acc) chk("rx_accept_timeout", 32'(acc), 32'd1);
  endtask

  // Wait for the answer, optionally stall tx_ready, then take it
  task automatic take_answer(input int stall, output logic [7:0] got);
    int n = 0;
    bit hold_bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 200);
    chk("tx_valid_seen", 32'(tx_valid), 32'd1);
    got = tx_data;
    if (stall > 0) begin
      rx_data  = 8'h5A;
      rx_valid = 1'b1;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        if (tx_valid !== 1'b1 || tx_data !== got || rx_ready !== 1'b0 || busy !== 1'b1)
          hold_bad = 1'b1;
      end
      rx_valid = 1'b0;
      chk("answer_hold_stable", 32'(hold_bad), 32'd0);
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
  endtask

  // Reference: all expected writes of a frame, straight from row/col rules
  task automatic check_writes(input logic [15:0] row, input string tag);
    wr_t exp_q[$];
    int  mism = 0;
    if (row < 16'd480) begin
      for (int i = 0; i < NB; i++) begin
        for (int p = 0; p < 2; p++) begin
          wr_t w;
          w.addr = AW'(int'(row) * 640 + 2 * i + p);
          w.data = (p == 0) ? pl[i][7:4] : pl[i][3:0];
          exp_q.push_back(w);
        end
      end
    end
    chk({tag, "_wr_count"}, 32'(wq.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
      if (wq[i] !== exp_q[i]) mism++;
    chk({tag, "_wr_content"}, 32'(mism), 32'd0);
  endtask

  task automatic run_frame(input logic [15:0] row, input logic [7:0] term, input int stall,
                           input logic [7:0] exp_tx, input bit exp_done, input string tag);
    logic [7:0] got;
    wq.delete();
    done_cnt = 0;
    send_byte(row[15:8]);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    send_byte(row[7:0]);
    chk({tag, "_err_row"}, 32'(err_row), 32'(row >= 16'd480));
    for (int i = 0; i < NB; i++) send_byte(pl[i]);
    send_byte(term);
    take_answer(stall, got);
    tick(3);
    chk({tag, "_tx_data"}, 32'(got), 32'(exp_tx));
    chk({tag, "_line_done"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, "_idle"}, 32'(busy | err_row), 32'd0);
    check_writes(row, tag);
  endtask

  initial begin
    logic [15:0] r;
    logic [7:0]  t;
    logic [7:0]  got;

    vt[0] = '{16'h0001, 8'h12, 1'b0, 8'h55, 8'hAA, 1'b1, 10};
    vt[1] = '{16'h01E0, 8'h00, 1'b1, 8'h55, 8'hEE, 1'b0, 0};
    vt[2] = '{16'h01DF, 8'h00, 1'b1, 8'h00, 8'hEE, 1'b0, 2};
    vt[3] = '{16'h0000, 8'hF0, 1'b0, 8'h55, 8'hAA, 1'b1, 0};
    vt[4] = '{16'h01DF, 8'h00, 1'b1, 8'h55, 8'hAA, 1'b1, 1};
    vt[5] = '{16'hFFFF, 8'h00, 1'b1, 8'h55, 8'hEE, 1'b0, 0};
    vt[6] = '{16'h0007, 8'h00, 1'b1, 8'h54, 8'hEE, 1'b0, 3};

    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    done_cnt = 0;
    tick(3);
    chk("rst_rx_ready",  32'(rx_ready),  32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_tx_valid",  32'(tx_valid),  32'd0);
    chk("rst_tx_data",   32'(tx_data),   32'd0);
    chk("rst_wr",        32'({wr_en, wr_addr, wr_data}), 32'd0);
    chk("rst_flags",     32'({line_done, err_row}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick(2);

    // Directed table
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NB; i++) pl[i] = vt[v].rnd ? 8'($urandom) : vt[v].fill;
      run_frame(vt[v].row, vt[v].term, vt[v].stall, vt[v].exp_tx, vt[v].exp_done,
                $sformatf("vec%0d", v));
      if (v == 2) begin
        chk("vec2_last_addr", (wq.size() > 0) ? 32'(wq[wq.size()-1].addr) : 32'hFFFF_FFFF,
            32'd307199);
      end
    end

    // Randomized frames against the model
    for (int f = 0; f < 4; f++) begin
      r = 16'($urandom_range(0, 520));
      t = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h55;
      for (int i = 0; i < NB; i++) pl[i] = 8'($urandom);
      run_frame(r, t, $urandom_range(0, 5),
                (t == 8'h55 && r < 16'd480) ? 8'hAA : 8'hEE,
                (t == 8'h55 && r < 16'd480), $sformatf("rnd%0d", f));
    end

    // Reset in the middle of a payload
    wq.delete();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h9C);
    send_byte(8'h3D);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_async", 32'({busy, rx_ready, wr_en, tx_valid, err_row}), 32'b01000);
    @(negedge clk) rst_n = 1'b1;
    wq.delete();
    tick(20);
    chk("midrst_no_writes", 32'(wq.size()), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    // Reset while an answer is pending
    for (int i = 0; i < NB; i++) pl[i] = 8'($urandom);
    send_byte(8'h00);
    send_byte(8'h03);
    for (int i = 0; i < NB; i++) send_byte(pl[i]);
    send_byte(8'h55);
    tick(1);
    chk("ansrst_pending", 32'(tx_valid), 32'd1);
    done_cnt = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("ansrst_tx_valid", 32'({tx_valid, tx_data}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tx_ready = 1'b1;
    tick(5);
    tx_ready = 1'b0;
    chk("ansrst_no_done", 32'(done_cnt), 32'd0);

    // Stop after five payload bytes
    send_byte(8'h00);
    send_byte(8'h05);
    for (int i = 0; i < 5; i++) send_byte(8'h77);
`ifdef ULW_TIMEOUT_EN
    take_answer(0, got);
    chk("timeout_nak", 32'(got), 32'hEE);
    tick(3);
`else
    tick(150);
    chk("notimeout_wait", 32'({busy, rx_ready, tx_valid}), 32'b110);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick(2);
`endif
    for (int i = 0; i < NB; i++) pl[i] = 8'($urandom);
    run_frame(16'h0010, 8'h55, 0, 8'hAA, 1'b1, "after_stop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global safety net
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
